reg_fifo_flow: RTL and testbench
================================

// Module: reg_fifo_flow
// PURPOSE
//  Parametrised shift-register FIFO, successor to the basic register FIFO used between
//  HLS stream stages. Adds concurrent read/write at full, occupancy count, registered
//  almost-full/almost-empty flags, synchronous flush and overflow/underflow pulses.
//  Sits on short-latency streams (parser->hash, hash->mem ctrl) where upstream
//  backpressure is driven by almost_full rather than full_n.
// PARAMETERS
//  DATA_BITS   8   payload width
//  DEPTH_BITS  4   log2 of storage depth; DEPTH = 1<<DEPTH_BITS, DEPTH_BITS >= 1
//  AF_LEVEL    12  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  nReset        in   1             asynchronous active-low reset
//  flush         in   1             synchronous clear of contents, priority over read/write
//  write         in   1             write request
//  din           in   DATA_BITS     write data
//  full_n        out  1             1 = space available
//  read          in   1             read request; pops dout
//  dout          out  DATA_BITS     oldest entry, valid while empty_n=1 (first-word fall-through)
//  empty_n       out  1             1 = data available
//  count         out  DEPTH_BITS+1  current occupancy, 0..DEPTH
//  almost_full   out  1             registered, count >= AF_LEVEL
//  almost_empty  out  1             registered, count <= AE_LEVEL
//  overflow      out  1             1-cycle pulse: write rejected previous cycle
//  underflow     out  1             1-cycle pulse: read on empty previous cycle
// BEHAVIOUR
//  - Reset (async assert, sync deassert at source): count=0, empty_n=0, full_n=1,
//    almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage not reset.
//  - Storage: shift register; accepted write loads mem[0] from din, mem[i]<=mem[i-1].
//    dout = mem[count-1] (combinational mux, no read latency). dout X when empty.
//  - wr_ok = write & (full_n | read); rd_ok = read & empty_n.
//    Full + read + write: both accepted, count stays DEPTH (gen 1 dropped this write).
//    Empty + read + write: write accepted, read ignored, underflow pulses, count -> 1.
//  - count_next: flush ? 0 : count + wr_ok - rd_ok. All flags registered from count_next:
//    empty_n = (count_next!=0), full_n = (count_next!=DEPTH), almost_* per thresholds.
//    Latency write->empty_n high = 1 cycle; read->full_n high = 1 cycle.
//  - flush: count->0 next cycle, same-cycle write/read discarded, no overflow/underflow
//    pulse generated for that cycle.
//  - overflow <= write & ~wr_ok & ~flush; underflow <= read & ~empty_n & ~flush.
//    Pulses never stick; count unchanged by rejected requests.
//  - Arithmetic in DEPTH_BITS+1 bits; count never wraps (saturation impossible by wr/rd_ok).
//  - Reset mid-operation: all outputs return to reset values immediately; in-flight
//    transfers lost; first post-reset write is entry 0.
// TESTING
//  1 Fill: 16 writes din=0..15 (defaults) -> count 16, full_n=0, almost_full high after
//    12th write edge, dout=0; 17th write alone -> overflow pulse, count 16.
//  2 Drain: 16 reads -> dout sequence 0..15, empty_n=0 after last, almost_empty high when
//    count<=2; extra read -> underflow pulse, count 0.
//  3 Full concurrent: at count 16 assert read+write din=0xAA -> count 16, no overflow,
//    0xAA appears as 16th dout after 15 further reads.
//  4 Empty concurrent: count 0, read+write din=0x55 -> count 1, underflow=1, dout=0x55.
//  5 Flush with write at count 7 -> count 0, empty_n=0, almost_empty=1, no pulses.
//  6 nReset low mid-fill (count 9) async -> outputs at reset values before next edge;
//    resume writes 0x01,0x02 -> dout=0x01, count 2; repeat with DEPTH_BITS=1, AF=AE=1.

Source files
------------

// File: rtl/reg_fifo_flow_if.sv
// Stream-side bundle of the register FIFO: request/data inputs plus status outputs.
// The master modport is the producer/consumer pair, the slave modport is the FIFO.
interface reg_fifo_flow_if #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_BITS = 4
);
    logic                  flush;
    logic                  write;
    logic [DATA_BITS-1:0]  din;
    logic                  full_n;
    logic                  read;
    logic [DATA_BITS-1:0]  dout;
    logic                  empty_n;
    logic [DEPTH_BITS:0]   count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, write, din, read,
        input  full_n, dout, empty_n, count,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, write, din, read,
        output full_n, dout, empty_n, count,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/reg_fifo_flow.sv
// Shift-register FIFO with first-word fall-through, occupancy count, registered
// almost flags, synchronous flush and one-cycle overflow/underflow pulses.
module reg_fifo_flow #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_BITS = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic           clk,
    input  logic           nReset,
    reg_fifo_flow_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [DEPTH_BITS-1:0] idx_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

    logic [DATA_BITS-1:0] mem [DEPTH];
    cnt_t                 count_q;
    cnt_t                 count_next;
    idx_t                 rd_idx;
    logic                 empty_n_q;
    logic                 full_n_q;
    logic                 almost_full_q;
    logic                 almost_empty_q;
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 shift_en;

    // A read at full frees the slot the concurrent write needs.
    always_comb begin
        wr_ok    = bus.write & (full_n_q | bus.read);
        rd_ok    = bus.read & empty_n_q;
        shift_en = wr_ok & ~bus.flush;
    end

    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count_q;
        if (bus.flush)
            count_next = '0;
        else if (wr_ok && !rd_ok)
            count_next = count_q + cnt_t'(1);
        else if (rd_ok && !wr_ok)
            count_next = count_q - cnt_t'(1);
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count_q        <= '0;
            empty_n_q      <= 1'b0;
            full_n_q       <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            count_q        <= count_next;
            empty_n_q      <= (count_next != '0);
            full_n_q       <= (count_next != DEPTH_C);
            almost_full_q  <= (count_next >= AF_C);
            almost_empty_q <= (count_next <= AE_C);
            overflow_q     <= bus.write & ~wr_ok & ~bus.flush;
            underflow_q    <= bus.read & ~empty_n_q & ~bus.flush;
        end
    end

    // NOTE: storage has no reset; count gates visibility, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= bus.din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    // Oldest entry sits at count-1; at count==DEPTH the low bits wrap to 0 and the
    // subtraction lands on DEPTH-1 as required.
    always_comb begin
        rd_idx = count_q[DEPTH_BITS-1:0] - idx_t'(1);
    end

    assign bus.dout         = mem[rd_idx];
    assign bus.count        = count_q;
    assign bus.empty_n      = empty_n_q;
    assign bus.full_n       = full_n_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_reg_fifo_flow.sv
// Drives a 16-deep and a 2-deep reg_fifo_flow from the same stimulus and checks both
// against queue-based models every cycle, plus directed literal expectations.
module tb_reg_fifo_flow;
    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       flush = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] din = 8'h00;
    bit         cmp_en = 1'b0;

    int total = 0;
    int bad   = 0;

    byte_q_t q_a, q_b;
    bit      ovf_a, udf_a, ovf_b, udf_b;

    reg_fifo_flow_if #(.DATA_BITS(8), .DEPTH_BITS(4)) bus_a ();
    reg_fifo_flow_if #(.DATA_BITS(8), .DEPTH_BITS(1)) bus_b ();

    assign bus_a.flush = flush;
    assign bus_a.write = write;
    assign bus_a.read  = read;
    assign bus_a.din   = din;
    assign bus_b.flush = flush;
    assign bus_b.write = write;
    assign bus_b.read  = read;
    assign bus_b.din   = din;

    reg_fifo_flow #(.DATA_BITS(8), .DEPTH_BITS(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut_a (
        .clk(clk), .nReset(n_reset), .bus(bus_a)
    );
    reg_fifo_flow #(.DATA_BITS(8), .DEPTH_BITS(1), .AF_LEVEL(1), .AE_LEVEL(1)) dut_b (
        .clk(clk), .nReset(n_reset), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: a read succeeds if anything is stored; a write succeeds if there is
    // room once that read has left.
    task automatic step(inout byte_q_t q, input int depth, output bit ovf, output bit udf);
        int n;
        bit rd_go, wr_go;
        if (flush) begin
            q.delete();
            ovf = 1'b0;
            udf = 1'b0;
        end else begin
            n     = q.size();
            rd_go = read && (n > 0);
            wr_go = write && ((n - int'(rd_go)) < depth);
            ovf   = write && !wr_go;
            udf   = read && (n == 0);
            if (rd_go) void'(q.pop_front());
            if (wr_go) q.push_back(din);
        end
    endtask

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            q_a.delete();
            q_b.delete();
            ovf_a = 1'b0; udf_a = 1'b0;
            ovf_b = 1'b0; udf_b = 1'b0;
        end else begin
            step(q_a, 16, ovf_a, udf_a);
            step(q_b, 2, ovf_b, udf_b);
        end
    end

    task automatic compare(input string tag, input int af, input int ae, input byte_q_t q,
                           input bit ovf, input bit udf, input logic [31:0] cnt,
                           input logic en, input logic fn, input logic afl, input logic ael,
                           input logic ov, input logic un, input logic [7:0] d, input int depth);
        int n;
        n = q.size();
        check({tag, ".count"}, cnt, n);
        check({tag, ".empty_n"}, en, n != 0);
        check({tag, ".full_n"}, fn, n != depth);
        check({tag, ".almost_full"}, afl, n >= af);
        check({tag, ".almost_empty"}, ael, n <= ae);
        check({tag, ".overflow"}, ov, ovf);
        check({tag, ".underflow"}, un, udf);
        if (n > 0) check({tag, ".dout"}, d, q[0]);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            compare("a", 12, 2, q_a, ovf_a, udf_a, bus_a.count, bus_a.empty_n, bus_a.full_n,
                    bus_a.almost_full, bus_a.almost_empty, bus_a.overflow, bus_a.underflow,
                    bus_a.dout, 16);
            compare("b", 1, 1, q_b, ovf_b, udf_b, bus_b.count, bus_b.empty_n, bus_b.full_n,
                    bus_b.almost_full, bus_b.almost_empty, bus_b.overflow, bus_b.underflow,
                    bus_b.dout, 2);
        end
    end

    task automatic drive(input bit w, input bit r, input bit f, input logic [7:0] d);
        write = w;
        read  = r;
        flush = f;
        din   = d;
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".count"}, bus_a.count, 0);
        check({tag, ".empty_n"}, bus_a.empty_n, 0);
        check({tag, ".full_n"}, bus_a.full_n, 1);
        check({tag, ".almost_empty"}, bus_a.almost_empty, 1);
        check({tag, ".almost_full"}, bus_a.almost_full, 0);
        check({tag, ".overflow"}, bus_a.overflow, 0);
        check({tag, ".underflow"}, bus_a.underflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        cmp_en  = 1'b1;
        check_reset_a("reset");
        check("reset.b_full_n", bus_b.full_n, 1);

        // Fill 0..15, then a rejected 17th write.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 10) check("fill.af_before_12", bus_a.almost_full, 0);
            if (i == 11) check("fill.af_at_12", bus_a.almost_full, 1);
        end
        check("fill.count", bus_a.count, 16);
        check("fill.full_n", bus_a.full_n, 0);
        check("fill.dout", bus_a.dout, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h77);
        check("fill.overflow", bus_a.overflow, 1);
        check("fill.count_after_ovf", bus_a.count, 16);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("fill.overflow_clears", bus_a.overflow, 0);

        // Drain in order, then a read on empty.
        for (int k = 0; k < 16; k++) begin
            check("drain.dout", bus_a.dout, 8'(k));
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            check("drain.almost_empty", bus_a.almost_empty, (16 - k - 1) <= 2);
        end
        check("drain.empty_n", bus_a.empty_n, 0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("drain.underflow", bus_a.underflow, 1);
        check("drain.count", bus_a.count, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("drain.underflow_clears", bus_a.underflow, 0);

        // Concurrent read+write at full.
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 8'(i));
        drive(1'b1, 1'b1, 1'b0, 8'hAA);
        check("full_rw.count", bus_a.count, 16);
        check("full_rw.overflow", bus_a.overflow, 0);
        for (int k = 1; k < 16; k++) begin
            check("full_rw.dout", bus_a.dout, 8'(k));
            drive(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check("full_rw.dout_aa", bus_a.dout, 8'hAA);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("full_rw.empty", bus_a.count, 0);

        // Concurrent read+write on empty.
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        check("empty_rw.count", bus_a.count, 1);
        check("empty_rw.underflow", bus_a.underflow, 1);
        check("empty_rw.dout", bus_a.dout, 8'h55);
        drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush with a concurrent write at count 7, then flush with a read on empty.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        check("flush.count_before", bus_a.count, 7);
        drive(1'b1, 1'b0, 1'b1, 8'hEE);
        check("flush.count", bus_a.count, 0);
        check("flush.empty_n", bus_a.empty_n, 0);
        check("flush.almost_empty", bus_a.almost_empty, 1);
        check("flush.overflow", bus_a.overflow, 0);
        check("flush.underflow", bus_a.underflow, 0);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("flush_rd.underflow", bus_a.underflow, 0);

        // Asynchronous reset mid-fill.
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
        check("arst.count_before", bus_a.count, 9);
        write = 1'b0;
        #2 n_reset = 1'b0;
        #1 check_reset_a("arst");
        check("arst.b_count", bus_b.count, 0);
        check("arst.b_empty_n", bus_b.empty_n, 0);
        @(negedge clk);
        n_reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h01);
        drive(1'b1, 1'b0, 1'b0, 8'h02);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("arst.dout", bus_a.dout, 8'h01);
        check("arst.count", bus_a.count, 2);
        check("arst.b_dout", bus_b.dout, 8'h01);
        check("arst.b_count", bus_b.count, 2);
        check("arst.b_full_n", bus_b.full_n, 0);
        check("arst.b_almost_full", bus_b.almost_full, 1);
        check("arst.b_almost_empty", bus_b.almost_empty, 0);
        drive(1'b0, 1'b0, 1'b1, 8'h00);

        // Randomised traffic, alternating fill-biased and drain-biased phases.
        for (int c = 0; c < 2000; c++) begin
            int wp, rp;
            bit w, r, f;
            wp = ((c / 200) % 2 == 0) ? 70 : 35;
            rp = ((c / 200) % 2 == 0) ? 35 : 70;
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < rp);
            f  = ($urandom_range(0, 99) < 2);
            drive(w, r, f, 8'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
